// File: rtl/rapcore_pkg.sv
// Shared register map and bit positions for the rapcore Wishbone command bridge.
package rapcore_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CMD    = 2'd2,
        REG_RESP   = 2'd3
    } reg_sel_e;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_EMPTY      = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_RESP_PEND  = 2;
    localparam int ST_OVERFLOW   = 3;
    localparam int ST_MOVE_DONE  = 4;
    localparam int ST_BUFFER_DTR = 5;
    localparam int ST_COUNT_LSB  = 8;

endpackage

// File: rtl/rapcore_sync_fifo.sv
// Single-clock FIFO with flush; head word is visible combinationally, zero when empty.
module rapcore_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/rapcore_wb_cmd_bridge.sv
// Wishbone slave feeding rapcore commands through a FIFO and latching its responses.
module rapcore_wb_cmd_bridge
    import rapcore_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    input  logic [31:0] resp_data_i,
    input  logic        resp_valid_i,
    input  logic        move_done_i,
    input  logic        buffer_dtr_i,
    output logic        enable_o,
    output logic        irq_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic        ack_reg;
    logic        enable_reg, enable_next;
    logic        irq_en_reg, irq_en_next;
    logic        resp_pending_reg, resp_pending_next;
    logic        overflow_reg, overflow_next;
    logic        irq_reg;
    logic [31:0] resp_reg, resp_next;

    logic        access, hit, wr, rd;
    logic        wr_ctrl, wr_cmd, flush, push, pop, ovf_set, ovf_clr, rd_resp;
    reg_sel_e    reg_sel;
    logic        fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0] status_word;
    logic [31:0] rd_data;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // The ack cycle is the single cycle in which an access takes effect.
    assign access  = ack_reg & wbs_cyc_i & wbs_stb_i;
    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = reg_sel_e'(wbs_adr_i[3:2]);
    assign wr      = access & hit & wbs_we_i;
    assign rd      = access & hit & ~wbs_we_i;

    assign wr_ctrl = wr & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    assign flush   = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
    assign wr_cmd  = wr & (reg_sel == REG_CMD);
    assign push    = wr_cmd & (wbs_sel_i == 4'hF);
    assign pop     = cmd_valid_o & cmd_ready_i;
    assign ovf_set = wr_cmd & ((wbs_sel_i != 4'hF) | (fifo_full & ~pop));
    assign ovf_clr = wr & (reg_sel == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[ST_OVERFLOW];
    assign rd_resp = rd & (reg_sel == REG_RESP);

    rapcore_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (wb_clk_i),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (wbs_dat_i),
        .dout   (cmd_data_o),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign cmd_valid_o = ~fifo_empty;

    always_comb begin
        enable_next       = enable_reg;
        irq_en_next       = irq_en_reg;
        resp_next         = resp_reg;
        resp_pending_next = resp_pending_reg;
        overflow_next     = overflow_reg;
        if (wr_ctrl) begin
            enable_next = wbs_dat_i[CTRL_ENABLE];
            irq_en_next = wbs_dat_i[CTRL_IRQ_EN];
        end
        // A fresh response beats the clearing read in the same cycle.
        if (resp_valid_i) begin
            resp_next         = resp_data_i;
            resp_pending_next = 1'b1;
        end else if (rd_resp) begin
            resp_pending_next = 1'b0;
        end
        if (ovf_set) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            ack_reg          <= 1'b0;
            enable_reg       <= 1'b0;
            irq_en_reg       <= 1'b0;
            resp_reg         <= '0;
            resp_pending_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            irq_reg          <= 1'b0;
        end else begin
            ack_reg          <= wbs_cyc_i & wbs_stb_i & ~ack_reg;
            enable_reg       <= enable_next;
            irq_en_reg       <= irq_en_next;
            resp_reg         <= resp_next;
            resp_pending_reg <= resp_pending_next;
            overflow_reg     <= overflow_next;
            irq_reg          <= resp_pending_next & irq_en_next;
        end
    end

    always_comb begin
        status_word                               = '0;
        status_word[ST_EMPTY]                     = fifo_empty;
        status_word[ST_FULL]                      = fifo_full;
        status_word[ST_RESP_PEND]                 = resp_pending_reg;
        status_word[ST_OVERFLOW]                  = overflow_reg;
        status_word[ST_MOVE_DONE]                 = move_done_i;
        status_word[ST_BUFFER_DTR]                = buffer_dtr_i;
        status_word[ST_COUNT_LSB +: CNT_W]        = fifo_count;
        rd_data = '0;
        if (rd) begin
            case (reg_sel)
                REG_CTRL: begin
                    rd_data[CTRL_ENABLE] = enable_reg;
                    rd_data[CTRL_IRQ_EN] = irq_en_reg;
                end
                REG_STATUS: rd_data = status_word;
                REG_RESP:   rd_data = resp_reg;
                default:    rd_data = '0;
            endcase
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = rd_data;
    assign enable_o  = enable_reg;
    assign irq_o     = irq_reg;

endmodule

// File: tb/tb_rapcore_wb_cmd_bridge.sv
// Self-checking bench: directed register scenarios plus random traffic against a queue model.
module tb_rapcore_wb_cmd_bridge;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        resetn = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o, cmd_data_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b0;
    logic [31:0] resp_data_i = '0;
    logic        resp_valid_i = 1'b0, move_done_i = 1'b0, buffer_dtr_i = 1'b0;
    logic        enable_o, irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    rapcore_wb_cmd_bridge #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(wb_clk_i), .resetn(resetn),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .resp_data_i(resp_data_i), .resp_valid_i(resp_valid_i),
        .move_done_i(move_done_i), .buffer_dtr_i(buffer_dtr_i),
        .enable_o(enable_o), .irq_o(irq_o)
    );

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    // Reference model: register values as plain bits, command FIFO as a queue.
    logic [31:0] m_q[$];
    bit          m_ack = 0, m_en = 0, m_irqen = 0, m_pend = 0, m_ovf = 0;
    logic [31:0] m_resp = '0;

    always @(posedge wb_clk_i) begin
        bit          acc, hit, pop;
        int          n;
        logic [1:0]  r;
        if (!resetn) begin
            m_q.delete();
            m_ack = 0; m_en = 0; m_irqen = 0; m_pend = 0; m_ovf = 0; m_resp = '0;
        end else begin
            acc = m_ack && wbs_cyc_i && wbs_stb_i;
            hit = (wbs_adr_i[31:4] == BASE[31:4]);
            r   = wbs_adr_i[3:2];
            n   = m_q.size();
            pop = (n > 0) && cmd_ready_i;
            if (acc && hit && wbs_we_i && r == 2'd0 && wbs_sel_i[0]) begin
                m_en    = wbs_dat_i[0];
                m_irqen = wbs_dat_i[2];
            end
            if (acc && hit && wbs_we_i && r == 2'd0 && wbs_sel_i[0] && wbs_dat_i[1]) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (acc && hit && wbs_we_i && r == 2'd2) begin
                    if (wbs_sel_i != 4'hF) m_ovf = 1;
                    else if (n < DEPTH || pop) m_q.push_back(wbs_dat_i);
                    else m_ovf = 1;
                end
            end
            if (acc && hit && wbs_we_i && r == 2'd1 && wbs_sel_i[0] && wbs_dat_i[3]) m_ovf = 0;
            if (resp_valid_i) begin
                m_resp = resp_data_i;
                m_pend = 1;
            end else if (acc && hit && !wbs_we_i && r == 2'd3) begin
                m_pend = 0;
            end
            m_ack = wbs_cyc_i && wbs_stb_i && !m_ack;
        end
    end

    function automatic logic [31:0] exp_read(input logic [31:0] adr);
        logic [31:0] v;
        int n;
        n = m_q.size();
        v = '0;
        if (adr[31:4] == BASE[31:4]) begin
            case (adr[3:2])
                2'd0: begin v[0] = m_en; v[2] = m_irqen; end
                2'd1: begin
                    v = 32'(n) << 8;
                    v[0] = (n == 0); v[1] = (n == DEPTH); v[2] = m_pend; v[3] = m_ovf;
                    v[4] = move_done_i; v[5] = buffer_dtr_i;
                end
                2'd3: v = m_resp;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    bit          rnd_side = 0;
    bit          hook_pop = 0;
    bit          hook_resp = 0;
    logic [31:0] hook_resp_data = '0;

    task automatic randomize_side();
        cmd_ready_i  = 1'($urandom_range(0, 1));
        resp_valid_i = ($urandom_range(0, 3) == 0);
        resp_data_i  = $urandom;
        move_done_i  = 1'($urandom_range(0, 1));
        buffer_dtr_i = 1'($urandom_range(0, 1));
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(cmd_valid_o), 32'(m_q.size() > 0));
        check_eq({tag, "_head"}, cmd_data_o, (m_q.size() > 0) ? m_q[0] : 32'h0);
        check_eq({tag, "_irq"}, 32'(irq_o), 32'(m_pend & m_irqen));
        check_eq({tag, "_en"}, 32'(enable_o), 32'(m_en));
    endtask

    task automatic step(input string tag);
        if (rnd_side) randomize_side();
        @(posedge wb_clk_i); #1;
        check_outputs(tag);
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input string tag, output logic [31:0] rdata);
        if (rnd_side) randomize_side();
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        @(posedge wb_clk_i); #1;
        check_eq({tag, "_ack"}, 32'(wbs_ack_o), 32'h1);
        rdata = wbs_dat_o;
        if (!we) check_eq({tag, "_rd"}, rdata, exp_read(adr));
        if (rnd_side) randomize_side();
        if (hook_pop) cmd_ready_i = 1;
        if (hook_resp) begin resp_valid_i = 1; resp_data_i = hook_resp_data; end
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        if (hook_pop) cmd_ready_i = 0;
        if (hook_resp) resp_valid_i = 0;
        check_eq({tag, "_ackdrop"}, 32'(wbs_ack_o), 32'h0);
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_drain [8];

        resetn = 0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_eq("rst_ack", 32'(wbs_ack_o), 32'h0);
        check_eq("rst_dat", wbs_dat_o, 32'h0);
        check_eq("rst_valid", 32'(cmd_valid_o), 32'h0);
        check_eq("rst_irq", 32'(irq_o), 32'h0);
        check_eq("rst_en", 32'(enable_o), 32'h0);
        resetn = 1;

        wb_access(0, BASE + 32'h4, 0, 4'hF, "st_reset", rd);
        check_eq("st_reset_val", rd, 32'h0000_0001);

        wb_access(1, BASE, 32'h5, 4'hF, "ctrl_wr", rd);
        wb_access(0, BASE, 0, 4'hF, "ctrl_rd", rd);
        check_eq("ctrl_val", rd, 32'h5);
        check_eq("ctrl_enable", 32'(enable_o), 32'h1);

        cmd_ready_i = 0;
        for (int i = 0; i < 9; i++) wb_access(1, BASE + 32'h8, 32'h10 + i, 4'hF, "push9", rd);
        wb_access(0, BASE + 32'h4, 0, 4'hF, "st_full", rd);
        check_eq("st_full_val", rd, 32'h0000_080A);
        wb_access(1, BASE + 32'h4, 32'h8, 4'hF, "ovf_clr", rd);
        cmd_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain1_word", cmd_data_o, 32'h10 + i);
            step("drain1");
        end
        check_eq("drain1_empty", 32'(cmd_valid_o), 32'h0);
        cmd_ready_i = 0;

        for (int i = 0; i < 8; i++) wb_access(1, BASE + 32'h8, 32'h20 + i, 4'hF, "fill", rd);
        hook_pop = 1;
        wb_access(1, BASE + 32'h8, 32'hABCD, 4'hF, "push_pop_full", rd);
        hook_pop = 0;
        wb_access(0, BASE + 32'h4, 0, 4'hF, "st_pp", rd);
        check_eq("st_pp_val", rd, 32'h0000_0802);
        for (int i = 0; i < 7; i++) exp_drain[i] = 32'h21 + i;
        exp_drain[7] = 32'hABCD;
        cmd_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain2_word", cmd_data_o, exp_drain[i]);
            step("drain2");
        end
        cmd_ready_i = 0;

        resp_valid_i = 1; resp_data_i = 32'hDEAD_BEEF;
        step("resp1");
        resp_valid_i = 0;
        check_eq("resp1_irq", 32'(irq_o), 32'h1);
        wb_access(0, BASE + 32'hC, 0, 4'hF, "resp1_rd", rd);
        check_eq("resp1_val", rd, 32'hDEAD_BEEF);
        check_eq("resp1_irq_clr", 32'(irq_o), 32'h0);
        resp_valid_i = 1; resp_data_i = 32'h1234;
        step("resp2");
        resp_valid_i = 0;
        hook_resp = 1; hook_resp_data = 32'h5555;
        wb_access(0, BASE + 32'hC, 0, 4'hF, "resp2_rd", rd);
        hook_resp = 0;
        check_eq("resp2_val", rd, 32'h1234);
        check_eq("resp2_irq_kept", 32'(irq_o), 32'h1);
        wb_access(0, BASE + 32'hC, 0, 4'hF, "resp3_rd", rd);
        check_eq("resp3_val", rd, 32'h5555);

        wb_access(0, BASE + 32'h10, 0, 4'hF, "miss_rd", rd);
        check_eq("miss_val", rd, 32'h0);
        wb_access(1, BASE + 32'h18, 32'h99, 4'hF, "miss_wr", rd);

        wb_access(1, BASE + 32'h8, 32'h77, 4'hF, "pre_rst_push", rd);
        resp_valid_i = 1; resp_data_i = 32'h4242;
        step("pre_rst_resp");
        resp_valid_i = 0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h4; wbs_sel_i = 4'hF;
        resetn = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge wb_clk_i); #1;
            check_eq("midrst_ack", 32'(wbs_ack_o), 32'h0);
        end
        check_outputs("midrst");
        wbs_cyc_i = 0; wbs_stb_i = 0;
        resetn = 1;
        step("post_rst");
        wb_access(0, BASE + 32'h4, 0, 4'hF, "post_rst_st", rd);
        check_eq("post_rst_st_val", rd, 32'h0000_0001);
        wb_access(0, BASE + 32'hC, 0, 4'hF, "post_rst_resp", rd);
        check_eq("post_rst_resp_val", rd, 32'h0);

        rnd_side = 1;
        for (int i = 0; i < 300; i++) begin
            int          op;
            logic [3:0]  sel;
            op  = $urandom_range(0, 9);
            sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            case (op)
                0, 1, 2: wb_access(1, BASE + 32'h8, $urandom, sel, "rnd_cmd", rd);
                3:       wb_access(0, BASE + 32'h4, 0, sel, "rnd_st_rd", rd);
                4:       wb_access(0, BASE + 32'hC, 0, sel, "rnd_resp_rd", rd);
                5:       wb_access(0, BASE, 0, sel, "rnd_ctrl_rd", rd);
                6:       wb_access(1, BASE, $urandom & 32'h0000_0007 & (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h5),
                                   sel, "rnd_ctrl_wr", rd);
                7:       wb_access(1, BASE + 32'h4, $urandom, sel, "rnd_st_wr", rd);
                8:       wb_access(1'($urandom_range(0, 1)), BASE + 32'h10 + 32'($urandom_range(0, 15) << 2),
                                   $urandom, sel, "rnd_miss", rd);
                default: step("rnd_idle");
            endcase
        end
        rnd_side = 0;
        cmd_ready_i = 0; resp_valid_i = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rapcore_wb_cmd_bridge.md
Name: rapcore_wb_cmd_bridge

Overview:
Wishbone slave (WB MI A) that gives the management SoC a register-mapped command path into the rapcore motion core, in parallel with the SPI pins. Buffers 32-bit command words in a FIFO and presents them to rapcore over a valid/ready stream. Latches rapcore response words and status (MOVE_DONE, BUFFER_DTR) for readback, and raises an interrupt. Sits between the wrapper's Wishbone ports and rapcore's command interface.

Parameters:
FIFO_DEPTH, 8, command FIFO entries; power of two, 2..64
BASE_ADDR, 32'h3000_0000, Wishbone base; decode compares wbs_adr_i[31:4]
CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived localparam)

Ports:
wb_clk_i  input  1  sole clock
resetn  input  1  synchronous, active-low reset
wbs_stb_i  input  1  WB strobe
wbs_cyc_i  input  1  WB cycle
wbs_we_i  input  1  WB write enable
wbs_sel_i  input  4  WB byte lanes
wbs_adr_i  input  32  WB address
wbs_dat_i  input  32  WB write data
wbs_ack_o  output  1  WB acknowledge
wbs_dat_o  output  32  WB read data
cmd_data_o  output  32  command word to rapcore (FIFO head)
cmd_valid_o  output  1  FIFO non-empty
cmd_ready_i  input  1  rapcore accepts head word
resp_data_i  input  32  response word from rapcore
resp_valid_i  input  1  one-cycle response strobe
move_done_i  input  1  rapcore MOVE_DONE
buffer_dtr_i  input  1  rapcore BUFFER_DTR
enable_o  output  1  CTRL.enable to rapcore ENINPUT
irq_o  output  1  interrupt to management SoC

Behaviour:
- Reset (resetn=0 at a clock edge): all outputs 0, FIFO empty, CTRL=0, RESP=0, resp_pending=0, overflow=0. Reset mid-transaction drops the access; no ack is issued for it.
- Bus access: valid = cyc & stb. ack is registered: asserted the cycle after valid while ack=0, held for exactly one cycle, then low for at least one cycle. Back-to-back accesses therefore complete every 2 cycles. The write side effect and the read data both take effect on the ack cycle.
- Decode: hit when adr[31:4]==BASE_ADDR[31:4]; register selected by adr[3:2]. A miss is still acked, reads return 0, writes are ignored, so the bus never hangs.
- 0x0 CTRL (RW): bit0 enable, bit2 irq_en. Byte-lane writes honour sel. bit1 flush is write-1, self-clearing, and reads as 0. Flush empties the FIFO on the ack cycle and overrides a same-cycle pop.
- 0x4 STATUS (RO, except bit3 W1C):
  - [CNT_W-1+8:8] FIFO count
  - bit0 empty, bit1 full, bit2 resp_pending, bit3 overflow (W1C)
  - bit4 move_done_i, bit5 buffer_dtr_i
  - All other bits 0.
- 0x8 CMD (WO): a write with sel==4'hF pushes wbs_dat_i.
  - A partial sel is ignored and sets overflow.
  - A push while full (and no same-cycle pop) is dropped and sets overflow.
  - Reads return 0.
- 0xC RESP (RO): returns the last latched response. A read clears resp_pending, unless resp_valid_i arrives in the same cycle; then the new data latches and pending stays 1.
- FIFO:
  - cmd_data_o is the head word, cmd_valid_o = !empty.
  - Pop on cmd_valid_o & cmd_ready_i.
  - Simultaneous push and pop: count unchanged, accepted even when full.
  - A push into an empty FIFO gives cmd_valid_o=1 on the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- resp_valid_i latches resp_data_i into RESP and sets resp_pending, regardless of bus activity.
- irq_o = resp_pending & irq_en, registered (1-cycle latency).
- enable_o = CTRL.enable, registered.

Decomposition:
- Shared package rapcore_pkg:
  - register offset constants REG_CTRL/REG_STATUS/REG_CMD/REG_RESP
  - CTRL bit indices
  - STATUS bit indices
- One sub-module is natural: rapcore_sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count). The bridge instantiates it at WIDTH=32.

Test Plan:
- Reset then read STATUS -> wbs_dat_o=32'h0000_0001 (empty), irq_o=0, enable_o=0, cmd_valid_o=0, ack 1 cycle after stb.
- Write CTRL=32'h5, read back -> 32'h5; enable_o=1 within 1 cycle of ack.
- cmd_ready_i=0; push 9 words (8'h10+i) with DEPTH=8 -> STATUS count=8, full=1, overflow=1. Then cmd_ready_i=1 -> cmd_data_o sequence 0x10..0x17, cmd_valid_o drops after the 8th.
- FIFO full, CMD write coincident with pop -> count stays 8, no overflow; the written word emerges last.
- resp_valid_i with 32'hDEAD_BEEF, irq_en=1 -> irq_o=1 next cycle. Read RESP -> 32'hDEAD_BEEF, irq_o=0 afterward. Repeat with resp_valid_i in the read's ack cycle -> pending stays 1.
- Access to BASE_ADDR+0x10 -> acked, reads 0. Assert resetn=0 mid-access -> no ack, all state cleared.
